// File: rtl/llf_pkg.sv
// rtl/llf_pkg.sv - shared helpers and FSM encoding for the linked-list multi-queue FIFO
package llf_pkg;

  // Bits needed to represent x (at least 1).
  function automatic int log2(input int x);
    int r;
    int v;
    r = 0;
    v = x;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Width of one occupancy count slice: must hold the value DEPTH.
  function automatic int count_width(input int depth);
    return log2(depth - 1) + 1;
  endfunction

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } llf_state_e;

endpackage

// File: rtl/linked_list_multi_fifo_if.sv
// rtl/linked_list_multi_fifo_if.sv - push/pop/status bundle of the linked-list multi-queue FIFO
interface linked_list_multi_fifo_if
  import llf_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int LOG2_FIFOS = log2(FIFOS - 1),
  parameter int LOG2_DEPTH = log2(DEPTH - 1)
) ();

  logic                              push;
  logic [LOG2_FIFOS-1:0]             push_fifo;
  logic [WIDTH-1:0]                  d;
  logic                              push_ok;
  logic                              pop;
  logic [LOG2_FIFOS-1:0]             pop_fifo;
  logic                              pop_ok;
  logic [WIDTH-1:0]                  q;
  logic                              q_valid;
  logic                              ready;
  logic [FIFOS-1:0]                  empty;
  logic [FIFOS*(LOG2_DEPTH+1)-1:0]   count;
  logic [LOG2_DEPTH:0]               free_count;
  logic                              full;
  logic                              almost_full;
  logic                              err;

  modport master (
    output push, push_fifo, d, pop, pop_fifo,
    input  push_ok, pop_ok, q, q_valid, ready, empty, count, free_count, full, almost_full, err
  );

  modport slave (
    input  push, push_fifo, d, pop, pop_fifo,
    output push_ok, pop_ok, q, q_valid, ready, empty, count, free_count, full, almost_full, err
  );

endinterface

// File: rtl/llf_ram.sv
// rtl/llf_ram.sv - 1W/1R storage array, synchronous read-before-write or asynchronous read
module llf_ram #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter bit SYNC_READ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  generate
    if (SYNC_READ) begin : g_sync
      // Non-blocking read of the same cell being written yields the old contents.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= r_mem[raddr];
      end
    end else begin : g_async
      logic w_unused;
      assign rdata    = r_mem[raddr];
      assign w_unused = ^{re, rst};
    end
  endgenerate

endmodule

// File: rtl/linked_list_multi_fifo.sv
// rtl/linked_list_multi_fifo.sv - FIFOS queues sharing one linked-list RAM; LLF_ERR_CHECK_EN builds the sticky err flag
module linked_list_multi_fifo
  import llf_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int AFULL      = 2,
  parameter int LOG2_FIFOS = log2(FIFOS - 1),
  parameter int LOG2_DEPTH = log2(DEPTH - 1)
) (
  input logic                     clk,
  input logic                     rst,
  linked_list_multi_fifo_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam logic [0:0] S_INIT = ST_INIT;
  localparam logic [0:0] S_RUN  = ST_RUN;

  typedef logic [LOG2_DEPTH-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [LOG2_FIFOS-1:0] fsel_t;

  logic [0:0] r_state;
  ptr_t       r_init_cnt;
  ptr_t       r_head [FIFOS];
  ptr_t       r_tail [FIFOS];
  cnt_t       r_cnt  [FIFOS];
  ptr_t       r_free_head;
  cnt_t       r_free_count;
  logic       r_q_valid;

  logic w_ready, w_pop_ok, w_push_ok, w_push_cnt_nz, w_same_single;
  ptr_t w_h, w_n, w_link_rdata, w_link_waddr, w_link_wdata;
  logic w_link_we;

  assign w_ready       = (r_state == S_RUN);
  assign w_pop_ok      = w_ready & bus.pop & (r_cnt[bus.pop_fifo] != '0);
  assign w_push_ok     = w_ready & bus.push & ((r_free_count != '0) | w_pop_ok);
  assign w_h           = r_head[bus.pop_fifo];
  // A simultaneous pop donates its entry to the push, bypassing the free list.
  assign w_n           = w_pop_ok ? w_h : r_free_head;
  assign w_push_cnt_nz = (r_cnt[bus.push_fifo] != '0);
  assign w_same_single = w_pop_ok & (bus.pop_fifo == bus.push_fifo) & (r_cnt[bus.push_fifo] == cnt_t'(1));

  always_comb begin
    w_link_we    = 1'b0;
    w_link_waddr = r_init_cnt;
    w_link_wdata = ptr_t'(r_init_cnt + 1'b1);
    if (!w_ready) begin
      w_link_we = 1'b1;
    end else if (w_pop_ok & !w_push_ok) begin
      w_link_we    = 1'b1;
      w_link_waddr = w_h;
      w_link_wdata = r_free_head;
    end else if (w_push_ok & w_push_cnt_nz) begin
      w_link_we    = 1'b1;
      w_link_waddr = r_tail[bus.push_fifo];
      w_link_wdata = w_n;
    end
  end

  llf_ram #(.WIDTH(LOG2_DEPTH), .DEPTH(DEPTH), .AW(LOG2_DEPTH), .SYNC_READ(1'b0)) u_link (
    .clk(clk), .rst(rst), .we(w_link_we), .waddr(w_link_waddr), .wdata(w_link_wdata),
    .re(1'b0), .raddr(w_n), .rdata(w_link_rdata)
  );

  llf_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(LOG2_DEPTH), .SYNC_READ(1'b1)) u_data (
    .clk(clk), .rst(rst), .we(w_push_ok), .waddr(w_n), .wdata(bus.d),
    .re(w_pop_ok), .raddr(w_h), .rdata(bus.q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_init_cnt   <= '0;
      r_free_head  <= '0;
      r_free_count <= '0;
      r_q_valid    <= 1'b0;
      for (int f = 0; f < FIFOS; f++) begin
        r_head[f] <= '0;
        r_tail[f] <= '0;
        r_cnt[f]  <= '0;
      end
    end else begin
      r_q_valid <= w_pop_ok;
      if (!w_ready) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == ptr_t'(DEPTH - 1)) begin
          r_state      <= S_RUN;
          r_free_head  <= '0;
          r_free_count <= cnt_t'(DEPTH);
        end
      end else begin
        for (int f = 0; f < FIFOS; f++) begin
          r_cnt[f] <= r_cnt[f]
                    + cnt_t'(w_push_ok && (bus.push_fifo == fsel_t'(f)))
                    - cnt_t'(w_pop_ok && (bus.pop_fifo == fsel_t'(f)));
        end
        if (w_pop_ok) r_head[bus.pop_fifo] <= w_link_rdata;
        if (w_push_ok) begin
          // Must follow the pop update so a single-entry same-queue bypass keeps head on h.
          if (!w_push_cnt_nz || w_same_single) r_head[bus.push_fifo] <= w_n;
          r_tail[bus.push_fifo] <= w_n;
        end
        if (w_push_ok & !w_pop_ok) begin
          r_free_head  <= w_link_rdata;
          r_free_count <= r_free_count - 1'b1;
        end else if (w_pop_ok & !w_push_ok) begin
          r_free_head  <= w_h;
          r_free_count <= r_free_count + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.empty = '0;
    bus.count = '0;
    for (int f = 0; f < FIFOS; f++) begin
      bus.empty[f]           = (r_cnt[f] == '0);
      bus.count[f*CW +: CW]  = r_cnt[f];
    end
  end

  assign bus.push_ok     = w_push_ok;
  assign bus.pop_ok      = w_pop_ok;
  assign bus.q_valid     = r_q_valid;
  assign bus.ready       = w_ready;
  assign bus.free_count  = r_free_count;
  assign bus.full        = (r_free_count == '0);
  assign bus.almost_full = (32'(r_free_count) < AFULL);

`ifdef LLF_ERR_CHECK_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = ((bus.push | bus.pop) & !w_ready)
                   | (w_ready & bus.push & (r_free_count == '0) & !w_pop_ok)
                   | (w_ready & bus.pop & (r_cnt[bus.pop_fifo] == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_linked_list_multi_fifo.sv
// tb/tb_linked_list_multi_fifo.sv - randomized queue-model bench for linked_list_multi_fifo
module tb_linked_list_multi_fifo;
  import llf_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int FIFOS = 4;
  localparam int AFULL = 2;
  localparam int LF    = log2(FIFOS - 1);
  localparam int CW    = log2(DEPTH - 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  linked_list_multi_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS)) bus ();

  linked_list_multi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS), .AFULL(AFULL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned mq [FIFOS][$];
  bit          m_ready;
  bit          m_err;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_total();
    int t = 0;
    for (int f = 0; f < FIFOS; f++) t += mq[f].size();
    return t;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < FIFOS; f++) mq[f].delete();
    m_err   = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic check_state();
    int  exp_free;
    int  dut_sum;
    bit  exp_err;
    exp_free = m_ready ? DEPTH - m_total() : 0;
    dut_sum  = 0;
    for (int f = 0; f < FIFOS; f++) begin
      check($sformatf("count%0d", f), bus.count[f*CW +: CW], mq[f].size());
      check($sformatf("empty%0d", f), bus.empty[f], mq[f].size() == 0);
      dut_sum += int'(bus.count[f*CW +: CW]);
    end
    check("free_count", bus.free_count, exp_free);
    check("full", bus.full, exp_free == 0);
    check("almost_full", bus.almost_full, exp_free < AFULL);
    check("ready", bus.ready, m_ready);
    if (m_ready) check("sum_invariant", dut_sum + int'(bus.free_count), DEPTH);
`ifdef LLF_ERR_CHECK_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    check("err", bus.err, exp_err);
  endtask

  task automatic step(input bit ps, input int pf, input int dv, input bit pp, input int qf);
    bit          e_pop;
    bit          e_push;
    int unsigned e_q;
    @(negedge clk);
    bus.push      = ps;
    bus.push_fifo = pf[LF-1:0];
    bus.d         = dv[WIDTH-1:0];
    bus.pop       = pp;
    bus.pop_fifo  = qf[LF-1:0];
    #1;
    e_pop  = m_ready && pp && (mq[qf].size() != 0);
    e_push = m_ready && ps && ((m_total() < DEPTH) || e_pop);
    check("pop_ok", bus.pop_ok, e_pop);
    check("push_ok", bus.push_ok, e_push);
    if ((ps || pp) && !m_ready) m_err = 1'b1;
    if (m_ready && ps && (m_total() == DEPTH) && !e_pop) m_err = 1'b1;
    if (m_ready && pp && (mq[qf].size() == 0)) m_err = 1'b1;
    @(posedge clk);
    #1;
    e_q = 0;
    if (e_pop) e_q = mq[qf].pop_front();
    if (e_push) mq[pf].push_back(int'(dv & 255));
    check("q_valid", bus.q_valid, e_pop);
    if (e_pop) check("q", bus.q, e_q);
    check_state();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  int cyc;
  int ord [3] = '{'h11, 'h22, 'h33};

  initial begin
    bus.push = 1'b0; bus.push_fifo = '0; bus.d = '0;
    bus.pop  = 1'b0; bus.pop_fifo  = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_q", bus.q, 0);
    check("reset_q_valid", bus.q_valid, 0);
    check_state();

    @(negedge clk) rst = 1'b0;
    cyc = 0;
    while (!bus.ready && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("init_cycles", cyc, DEPTH);
    m_ready = 1'b1;
    check_state();

    for (int i = 0; i < 3; i++) step(1'b1, 2, ord[i], 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, 1'b1, 2);
      check("order_q", bus.q, ord[i]);
    end

    for (int i = 0; i < DEPTH; i++) step(1'b1, i % FIFOS, int'($urandom_range(0, 255)), 1'b0, 0);
    step(1'b1, 1, 'h5A, 1'b0, 0);
    step(1'b1, 3, 'h77, 1'b1, 0);
    for (int f = 0; f < FIFOS; f++) begin
      while (mq[f].size() != 0) step(1'b0, 0, 0, 1'b1, f);
    end

    step(1'b1, 1, 'hAA, 1'b0, 0);
    step(1'b1, 1, 'hBB, 1'b1, 1);
    check("bypass_q", bus.q, 'hAA);
    step(1'b0, 0, 0, 1'b1, 1);
    check("bypass_q2", bus.q, 'hBB);

    step(1'b0, 0, 0, 1'b1, 3);
    step(1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, 0, 1'b0, 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 55, int'($urandom_range(0, FIFOS - 1)), int'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 50, int'($urandom_range(0, FIFOS - 1)));
    end

    for (int i = 0; i < 6; i++) step(1'b1, i % FIFOS, 'h40 + i, 1'b0, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    model_reset();
    check("midreset_q_valid", bus.q_valid, 0);
    check_state();
    @(negedge clk) rst = 1'b0;
    step(1'b1, 0, 'h55, 1'b1, 0);
    cyc = 0;
    while (!bus.ready && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reinit_ready", bus.ready, 1);
    m_ready = 1'b1;
    check_state();
    step(1'b1, 3, 'hC3, 1'b0, 0);
    step(1'b1, 3, 'h3C, 1'b1, 3);
    step(1'b0, 0, 0, 1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
